// File: rtl/clock_enable_gen_if.sv
// Control/strobe bundle for clock_enable_gen. The master side drives the
// enable and the tap-select request; the slave side returns the strobes and status.
interface clock_enable_gen_if #(
  parameter int TAPS  = 6,
  parameter int SEL_W = 3
);
  logic             pll_ena;
  logic [SEL_W-1:0] sel;
  logic             sel_valid;
  logic             sel_ready;
  logic [TAPS-1:0]  tap_en;
  logic             clk_en;
  logic             locked;

  modport master (
    output pll_ena, sel, sel_valid,
    input  sel_ready, tap_en, clk_en, locked
  );

  modport slave (
    input  pll_ena, sel, sel_valid,
    output sel_ready, tap_en, clk_en, locked
  );
endinterface

// File: rtl/clock_enable_gen.sv
// Fabric clock-enable generator. A prescaler plus a binary counter produce TAPS
// aligned strobes at clk_in/(BASE_DIV*2^k). A settle/lock sequence gates them,
// and clk_en follows one selectable tap, changing taps only on a strobe of the
// slower of the old and new taps so no enable spacing is ever shorter than
// either tap's period.

// One tap decoder: strobe when the prescaler is at zero and the low k counter
// bits are zero.
module clock_enable_gen_tap #(
  parameter int K  = 0,
  parameter int CW = 1
) (
  input  logic          active,
  input  logic          pre_zero,
  input  logic [CW-1:0] cnt,
  output logic          strobe
);
  localparam logic [CW-1:0] MASK = CW'((64'd1 << K) - 64'd1);

  assign strobe = active & pre_zero & ~|(cnt & MASK);
endmodule

module clock_enable_gen #(
  parameter int TAPS          = 6,
  parameter int BASE_DIV      = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int SEL_W         = 3
) (
  input logic            clk_in,
  input logic            nres,
  clock_enable_gen_if.slave bus
);
  localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int CW = TAPS - 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0]    PRE_LAST    = PW'(BASE_DIV - 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_MAX     = SEL_W'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, SWITCH} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    pre, pre_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [SW-1:0]    settle, settle_n;
  logic [SEL_W-1:0] cur_sel, cur_sel_n;
  logic [SEL_W-1:0] nxt_sel, nxt_sel_n;
  logic [SEL_W-1:0] sel_c, max_sel;
  logic             active, pre_zero, accept, switch_now;
  logic [TAPS-1:0]  tap;

  assign active   = (state == RUN) || (state == SWITCH);
  assign pre_zero = (pre == '0);
  assign sel_c    = (32'(bus.sel) >= 32'(TAPS)) ? SEL_MAX : bus.sel;
  assign accept   = bus.sel_valid & bus.sel_ready;
  assign max_sel  = (nxt_sel > cur_sel) ? nxt_sel : cur_sel;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    clock_enable_gen_tap #(.K(k), .CW(CW)) u_tap (
      .active   (active),
      .pre_zero (pre_zero),
      .cnt      (cnt),
      .strobe   (tap[k])
    );
  end

  // A strobe on the slower tap is also a strobe on the faster one, so the
  // handover cycle always carries clk_en=1 from the old tap.
  assign switch_now    = |(tap & (TAPS'(1) << max_sel));
  assign bus.tap_en    = tap;
  assign bus.clk_en    = |(tap & (TAPS'(1) << cur_sel));
  assign bus.locked    = active;
  assign bus.sel_ready = (state != SWITCH);

  // Next-state and datapath update; pll_ena low overrides everything.
  always_comb begin
    state_n   = state;
    pre_n     = pre;
    cnt_n     = cnt;
    settle_n  = settle;
    cur_sel_n = cur_sel;
    nxt_sel_n = nxt_sel;
    if (!bus.pll_ena) begin
      state_n  = IDLE;
      pre_n    = '0;
      cnt_n    = '0;
      settle_n = '0;
      if (state == SWITCH) cur_sel_n = nxt_sel;
      else if (accept)     cur_sel_n = sel_c;
    end else begin
      if (active) begin
        if (pre == PRE_LAST) begin
          pre_n = '0;
          cnt_n = cnt + 1'b1;
        end else begin
          pre_n = pre + 1'b1;
        end
      end
      case (state)
        IDLE: begin
          state_n  = SETTLE;
          settle_n = '0;
          if (accept) cur_sel_n = sel_c;
        end
        SETTLE: begin
          if (accept) cur_sel_n = sel_c;
          if (settle == SETTLE_LAST) begin
            state_n = RUN;
            pre_n   = '0;
            cnt_n   = '0;
          end else begin
            settle_n = settle + 1'b1;
          end
        end
        RUN: begin
          if (accept && (sel_c != cur_sel)) begin
            nxt_sel_n = sel_c;
            state_n   = SWITCH;
          end
        end
        SWITCH: begin
          if (switch_now) begin
            cur_sel_n = nxt_sel;
            state_n   = RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge nres) begin
    if (!nres) begin
      state   <= IDLE;
      pre     <= '0;
      cnt     <= '0;
      settle  <= '0;
      cur_sel <= '0;
      nxt_sel <= '0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      cnt     <= cnt_n;
      settle  <= settle_n;
      cur_sel <= cur_sel_n;
      nxt_sel <= nxt_sel_n;
    end
  end
endmodule
